// File: rtl/mem_access_unit.sv
// Load/store engine between the CPU datapath memory port and the external req/ack bus.
// Runs one bus transaction per start, returns load data with a one-cycle writeback strobe.
module mem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              is_store,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        dest,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ld,
   output logic [DATA_W-1:0] ld_data,
   output logic [3:0]        ld_reg,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic              bus_err,
   input  logic [DATA_W-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, FIN, ERR} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] cnt;
   logic        is_store_q;
   logic [3:0]  dest_q;
   logic        accept;
   logic        misaligned;
   logic        load_done;

   assign accept     = (state == IDLE) && start;
   assign misaligned = (addr[1:0] != 2'b00);
   assign load_done  = (state == REQ) && (state_next == FIN) && !is_store_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // bus_err outranks bus_ack; the timeout only fires when neither arrived
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = misaligned ? ERR : REQ;
            end
         end
         REQ: begin
            if (bus_err) begin
               state_next = ERR;
            end else if (bus_ack) begin
               state_next = FIN;
            end else if (cnt == CNT_LAST) begin
               state_next = ERR;
            end
         end
         FIN:     state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         ld         <= 1'b0;
         ld_data    <= '0;
         ld_reg     <= '0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         cnt        <= '0;
         is_store_q <= 1'b0;
         dest_q     <= '0;
      end else begin
         busy    <= (state_next != IDLE);
         done    <= (state_next == FIN);
         err     <= (state_next == ERR);
         ld      <= load_done;
         bus_req <= (state_next == REQ);
         bus_we  <= (state_next == REQ) && (accept ? is_store : is_store_q);
         if (accept) begin
            is_store_q <= is_store;
            dest_q     <= dest;
         end
         if (accept && !misaligned) begin
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_wdata <= wdata;
         end
         if (load_done) begin
            ld_data <= bus_rdata;
            ld_reg  <= dest_q;
         end
         if ((state == REQ) && (state_next == REQ)) begin
            cnt <= cnt + 16'd1;
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected completions,
// a negedge monitor pops and compares whenever done or err pulses.
module tb_mem_access_unit;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        is_store;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  dest;
   logic        busy;
   logic        done;
   logic        err;
   logic        ld;
   logic [31:0] ld_data;
   logic [3:0]  ld_reg;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   typedef struct {
      bit          is_err;
      bit          is_ld;
      logic [31:0] data;
      logic [3:0]  dreg;
   } exp_t;

   exp_t        sb_q[$];
   int          assertions = 0;
   int          failures   = 0;
   logic [31:0] last_ld_data = 32'h0;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store),
      .addr(addr), .wdata(wdata), .dest(dest), .busy(busy), .done(done),
      .err(err), .ld(ld), .ld_data(ld_data), .ld_reg(ld_reg),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
      .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done/err pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (done || err) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_completion", {62'd0, done, err}, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("done", done, !e.is_err);
            checkOutput("err", err, e.is_err);
            checkOutput("ld", ld, e.is_ld);
            checkOutput("ld_data", ld_data, e.data);
            if (e.is_ld) checkOutput("ld_reg", ld_reg, e.dreg);
         end
      end
   end

   // Issues one request, answers the bus on request cycle waits+1, and checks bus-side behaviour
   task automatic applyStimulus(input bit st, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] d, input int waits, input bit give_ack,
                                input bit give_err, input logic [31:0] rdata,
                                input int exp_req_cycles, input exp_t e);
      int req_cycles;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b1; is_store = st; addr = a; wdata = wd; dest = d;
      @(negedge clk);
      start = 1'b0;
      req_cycles = 0;
      while (bus_req && req_cycles < 50) begin
         req_cycles++;
         checkOutput("bus_addr", bus_addr, a);
         checkOutput("bus_we", bus_we, st);
         if (st) checkOutput("bus_wdata", bus_wdata, wd);
         if (req_cycles == waits + 1) begin
            bus_ack = give_ack; bus_err = give_err; bus_rdata = rdata;
         end
         @(negedge clk);
         bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h5555_5555;
      end
      checkOutput("req_cycles", req_cycles, exp_req_cycles);
      checkOutput("busy_final_cycle", busy, 1'b1);
      @(negedge clk);
      checkOutput("busy_released", busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; is_store = 1'b0; addr = '0; wdata = '0; dest = '0;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h5555_5555;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_bus_req", bus_req, 1'b0);
      checkOutput("rst_done_err_ld", {done, err, ld}, 3'b000);
      checkOutput("rst_ld_data", ld_data, 32'h0);
      checkOutput("rst_bus_addr", bus_addr, 32'h0);
      reset_n = 1'b1;

      $display("[TB] load with three wait cycles");
      applyStimulus(1'b0, 32'h100, 32'h0, 4'd5, 3, 1'b1, 1'b0, 32'hDEAD_BEEF, 4,
                    '{is_err: 1'b0, is_ld: 1'b1, data: 32'hDEAD_BEEF, dreg: 4'd5});
      last_ld_data = 32'hDEAD_BEEF;

      $display("[TB] zero-wait store");
      applyStimulus(1'b1, 32'h40, 32'h1234_5678, 4'd0, 0, 1'b1, 1'b0, 32'h0, 1,
                    '{is_err: 1'b0, is_ld: 1'b0, data: 32'hDEAD_BEEF, dreg: 4'd0});

      $display("[TB] misaligned load");
      applyStimulus(1'b0, 32'h102, 32'h0, 4'd3, 0, 1'b0, 1'b0, 32'h0, 0,
                    '{is_err: 1'b1, is_ld: 1'b0, data: 32'hDEAD_BEEF, dreg: 4'd0});

      $display("[TB] timeout with no ack");
      applyStimulus(1'b0, 32'h80, 32'h0, 4'd7, 100, 1'b0, 1'b0, 32'h0, 4,
                    '{is_err: 1'b1, is_ld: 1'b0, data: 32'hDEAD_BEEF, dreg: 4'd0});
      bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h5555_5555;
      @(negedge clk);
      checkOutput("late_ack_busy", busy, 1'b0);
      checkOutput("late_ack_ld_data", ld_data, last_ld_data);

      $display("[TB] bus_err together with bus_ack");
      applyStimulus(1'b0, 32'h104, 32'h0, 4'd9, 1, 1'b1, 1'b1, 32'hCAFE_F00D, 2,
                    '{is_err: 1'b1, is_ld: 1'b0, data: 32'hDEAD_BEEF, dreg: 4'd0});

      $display("[TB] start while busy, then reset mid-request");
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; addr = 32'h200; dest = 4'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; addr = 32'h300; dest = 4'd4;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_start_ignored", bus_addr, 32'h200);
      checkOutput("busy_req_held", bus_req, 1'b1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checkOutput("midreset_bus_req", bus_req, 1'b0);
      checkOutput("midreset_busy", busy, 1'b0);
      checkOutput("midreset_ld_data", ld_data, 32'h0);
      checkOutput("midreset_bus_addr", bus_addr, 32'h0);
      last_ld_data = 32'h0;
      repeat (2) @(negedge clk);

      $display("[TB] load after reset");
      applyStimulus(1'b0, 32'h8, 32'h0, 4'hA, 0, 1'b1, 1'b0, 32'h0BAD_F00D, 1,
                    '{is_err: 1'b0, is_ld: 1'b1, data: 32'h0BAD_F00D, dreg: 4'hA});

      $display("[TB] misaligned store");
      applyStimulus(1'b1, 32'h43, 32'hFFFF_0000, 4'd0, 0, 1'b0, 1'b0, 32'h0, 0,
                    '{is_err: 1'b1, is_ld: 1'b0, data: 32'h0BAD_F00D, dreg: 4'd0});

      repeat (2) @(negedge clk);
      checkOutput("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
